// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor controller.
package serial_sub_pkg;

    localparam int unsigned SERIAL_SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: x - y - bi -> d, borrow-out bo.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference and borrow of a single bit position
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: computes a - b - bin LSB-first
// through one full_sub_cell, with start/in_ready and out_valid/out_ready
// handshakes.
// Optional macro SERIAL_SUB_FLAGS_EN adds registered zero/neg result flags.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_SUB_DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             in_ready,
    output logic             busy,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             out_valid,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             zero,
    output logic             neg,
`endif
    input  logic             out_ready
);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               cell_d;
    logic               cell_bo;
    logic               last_bit;

    full_sub_cell u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Control FSM, operand shift registers, bit counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    diff <= {cell_d, diff[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= cell_bo;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        borrow    <= cell_bo;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    logic zero_acc;

    // Serial zero detection over the produced diff bits; flags land with out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_acc <= 1'b0;
            zero     <= 1'b0;
            neg      <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                zero_acc <= 1'b1;
            end else if (state == RUN) begin
                zero_acc <= zero_acc & ~cell_d;
                if (last_bit) begin
                    zero <= zero_acc & ~cell_d;
                    neg  <= cell_bo;
                end
            end
        end
    end
`else
    // Result flags are not built in this configuration.
`endif

endmodule
